// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller: tracks in-flight producers from EX through the
// last forwarding stage, drives registered operand selects and a combinational stall.
module hazard_forward_unit #(
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_AVAIL = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    output logic              stall,
    output logic [SEL_W-1:0]  ForwardA,
    output logic [SEL_W-1:0]  ForwardB,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [SEL_W:0] LOAD_AVAIL_C = (SEL_W + 1)'(LOAD_AVAIL);

    logic              r_valid [DEPTH];
    logic [ADDR_W-1:0] r_rd    [DEPTH];
    logic              r_wr    [DEPTH];
    logic              r_ld    [DEPTH];
    logic [SEL_W-1:0]  r_fwd_a;
    logic [SEL_W-1:0]  r_fwd_b;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_hit_a, w_hit_b;
    logic              w_ld_a, w_ld_b;
    logic [SEL_W-1:0]  w_sel_a, w_sel_b;
    logic              w_haz_a, w_haz_b;
    logic              w_adv;

    // Scan from the oldest stage down so the nearest match overwrites farther ones.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_valid[k] && r_wr[k] && (r_rd[k] != '0)) begin
                if (r_rd[k] == id_rs) begin
                    w_hit_a = 1'b1;
                    w_ld_a  = r_ld[k];
                    w_sel_a = SEL_W'(k + 1);
                end
                if (r_rd[k] == id_rt) begin
                    w_hit_b = 1'b1;
                    w_ld_b  = r_ld[k];
                    w_sel_b = SEL_W'(k + 1);
                end
            end
        end
    end

    // With forwarding, only a load whose data is not yet in a forwardable latch blocks.
    assign w_haz_a = fwd_en ? (w_hit_a & w_ld_a & ({1'b0, w_sel_a} < LOAD_AVAIL_C)) : w_hit_a;
    assign w_haz_b = fwd_en ? (w_hit_b & w_ld_b & ({1'b0, w_sel_b} < LOAD_AVAIL_C)) : w_hit_b;

    assign stall = id_valid & ~flush & ~rst & (w_haz_a | w_haz_b);
    assign w_adv = id_valid & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_rd[k]    <= '0;
                r_wr[k]    <= 1'b0;
                r_ld[k]    <= 1'b0;
            end
            r_fwd_a     <= '0;
            r_fwd_b     <= '0;
            r_stall_cnt <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_wr[k]    <= r_wr[k-1];
                r_ld[k]    <= r_ld[k-1];
            end
            r_valid[0] <= w_adv;
            r_rd[0]    <= id_rd;
            r_wr[0]    <= id_regWrite;
            r_ld[0]    <= id_memRead;
            r_fwd_a    <= (fwd_en & w_adv & w_hit_a) ? w_sel_a : '0;
            r_fwd_b    <= (fwd_en & w_adv & w_hit_b) ? w_sel_b : '0;
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign ForwardA    = r_fwd_a;
    assign ForwardB    = r_fwd_b;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: table vectors, directed corners and random stimulus
// checked against a cycle-history reference model; a 4-bit-counter copy covers saturation.
module tb_hazard_forward_unit;

    localparam int D = 2;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst, fwd_en, flush, id_valid, id_regWrite, id_memRead;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        stall, stall2;
    logic [1:0]  fa, fb, fa2, fb2;
    logic [15:0] cnt;
    logic [3:0]  cnt2;

    always #5 clk = ~clk;

    hazard_forward_unit #(.ADDR_W(5), .DEPTH(D), .LOAD_AVAIL(L), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regWrite(id_regWrite),
        .id_memRead(id_memRead), .stall(stall), .ForwardA(fa), .ForwardB(fb),
        .stall_count(cnt)
    );

    hazard_forward_unit #(.ADDR_W(5), .DEPTH(D), .LOAD_AVAIL(L), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_regWrite(id_regWrite),
        .id_memRead(id_memRead), .stall(stall2), .ForwardA(fa2), .ForwardB(fb2),
        .stall_count(cnt2)
    );

    typedef struct {
        logic r, f, fl, v;
        logic [4:0] rs, rt, rd;
        logic wr, ld;
        logic es;
        int   efa, efb;
    } vec_t;

    vec_t tbl[26];
    vec_t cur;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: what entered EX on each cycle, indexed by cycle number.
    logic       hv [64];
    logic       hw [64];
    logic       hl [64];
    logic [4:0] hr [64];
    int  cyc = 0;
    int  last_rst = -1;
    int  m_fa = 0, m_fb = 0, m_cnt = 0;
    bit  primed = 0;
    bit  fA, fB, lA, lB, m_stl, m_adv;
    int  dA, dB;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(logic f, logic fl, logic v, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic wr, logic ld, logic es, int efa, int efb);
        vec_t x;
        x.r = 1'b0; x.f = f; x.fl = fl; x.v = v; x.rs = rs; x.rt = rt; x.rd = rd;
        x.wr = wr; x.ld = ld; x.es = es; x.efa = efa; x.efb = efb;
        return x;
    endfunction

    // Nearest producer (fewest cycles since it entered EX) that writes register s.
    task automatic lookup(input logic [4:0] s, output bit f, output int d, output bit ld);
        int c;
        int i;
        f = 0; d = 0; ld = 0;
        for (int a = 1; a <= D; a++) begin
            c = cyc - a;
            if (!f && c >= 0 && c > last_rst) begin
                i = c % 64;
                if (hv[i] && hw[i] && hr[i] == s && s != 5'd0) begin
                    f = 1; d = a; ld = hl[i];
                end
            end
        end
    endtask

    task automatic drive_check(input vec_t x);
        bit hzA, hzB;
        cur = x;
        rst = x.r; fwd_en = x.f; flush = x.fl; id_valid = x.v;
        id_rs = x.rs; id_rt = x.rt; id_rd = x.rd; id_regWrite = x.wr; id_memRead = x.ld;
        @(negedge clk);
        lookup(x.rs, fA, dA, lA);
        lookup(x.rt, fB, dB, lB);
        hzA = x.f ? (fA && lA && dA < L) : fA;
        hzB = x.f ? (fB && lB && dB < L) : fB;
        m_stl = x.v && !x.fl && !x.r && (hzA || hzB);
        m_adv = x.v && !m_stl && !x.fl;
        chk("stall", stall, m_stl);
        chk("stall_c4", stall2, m_stl);
        if (primed) begin
            chk("ForwardA", fa, m_fa);
            chk("ForwardB", fb, m_fb);
            chk("stall_count", cnt, m_cnt);
            chk("ForwardA_c4", fa2, m_fa);
            chk("ForwardB_c4", fb2, m_fb);
            chk("stall_count_c4", cnt2, (m_cnt > 15) ? 15 : m_cnt);
        end
    endtask

    task automatic clock_update();
        int i;
        @(posedge clk);
        i = cyc % 64;
        if (cur.r) begin
            last_rst = cyc;
            hv[i] = 0;
            m_fa = 0; m_fb = 0; m_cnt = 0;
        end else begin
            hv[i] = m_adv; hw[i] = cur.wr; hl[i] = cur.ld; hr[i] = cur.rd;
            m_fa = (cur.f && m_adv && fA) ? dA : 0;
            m_fb = (cur.f && m_adv && fB) ? dB : 0;
            if (m_stl && m_cnt < 65535) m_cnt++;
        end
        cyc++;
        primed = 1;
        #1;
    endtask

    task automatic step(input vec_t x);
        drive_check(x);
        clock_update();
    endtask

    function automatic vec_t rnd(logic r);
        vec_t x;
        x = mk(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
        x.r = r;
        return x;
    endfunction

    initial begin
        vec_t x;
        for (int i = 0; i < 64; i++) begin
            hv[i] = 0; hw[i] = 0; hl[i] = 0; hr[i] = '0;
        end
        rst = 1; fwd_en = 1; flush = 0; id_valid = 0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_regWrite = 0; id_memRead = 0;

        tbl[0]  = mk(1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
        tbl[7]  = mk(1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[11] = mk(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0);
        tbl[12] = mk(1, 0, 1, 0, 5, 0, 0, 0, 1, 0, 0);
        tbl[13] = mk(1, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[15] = mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[16] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0);
        tbl[19] = mk(1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 0);
        tbl[23] = mk(0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 0);
        tbl[24] = mk(0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with random inputs
        step(rnd(1));
        step(rnd(1));
        chk("rst_ForwardA", fa, 0);
        chk("rst_ForwardB", fb, 0);
        chk("rst_stall_count", cnt, 0);

        foreach (tbl[i]) begin
            drive_check(tbl[i]);
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].es);
            chk($sformatf("tbl%0d_ForwardA", i), fa, tbl[i].efa);
            chk($sformatf("tbl%0d_ForwardB", i), fb, tbl[i].efb);
            clock_update();
        end
        chk("tbl_stall_count", cnt, 3);

        // Reset arriving while a load-use stall is pending drops the stall at once
        step(mk(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0));
        x = mk(1, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        x.r = 1;
        drive_check(x);
        chk("rst_mid_stall", stall, 0);
        clock_update();
        chk("rst_mid_cnt", cnt, 0);

        // Continuous no-forwarding self-dependency: 12 issues, 24 stall cycles
        for (int i = 0; i < 36; i++) step(mk(0, 0, 1, 3, 0, 3, 1, 0, 0, 0, 0));
        chk("sat_count16", cnt, 24);
        chk("sat_count4", cnt2, 15);

        for (int i = 0; i < 3000; i++) step(rnd($urandom_range(0, 99) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
